in_port: RTL
============

IN_PORT -- requirements
Module: in_port

Interface
REQ-001 The block SHALL have parameter DEB_CYCLES, default 16'd50000, meaning consecutive stable cycles needed to accept a button level change.
REQ-002 The block SHALL have port clock, input, 1: single clock, all state on posedge.
REQ-003 The block SHALL have port n_reset, input, 1: reset, synchronous, active-low.
REQ-004 The block SHALL have port inp, input, 16: raw board switches, asynchronous.
REQ-005 The block SHALL have port btn, input, 1: raw push button, active-high, asynchronous, bouncing.
REQ-006 The block SHALL have port rd_req, input, 1: processor IN-instruction request, level, held until rd_ack.
REQ-007 The block SHALL have port inpval, output, 16: captured switch value, registered.
REQ-008 The block SHALL have port rd_ack, output, 1: one-cycle registered pulse; inpval is valid while it is high.
REQ-009 The block SHALL have port valid, output, 1: captured value held and unread.
REQ-010 The block SHALL have port overrun, output, 1: sticky, an unread value was overwritten.
REQ-011 The block SHALL have port waiting, output, 1: processor is stalled on an empty port.

Function
REQ-012 inp and btn SHALL each pass through a 2-flop synchronizer before any use.
REQ-013 Debounced button btn_db SHALL toggle only after synchronized btn differs from btn_db for DEB_CYCLES consecutive cycles; the counter SHALL clear whenever the two agree.
REQ-014 The debounce counter SHALL be 16 bits and SHALL saturate, never wrap.
REQ-015 press SHALL be a one-cycle pulse on the btn_db 0->1 edge; the release edge SHALL NOT generate an event.
REQ-016 Capture on press SHALL load inpval from the synchronized inp of the same cycle.
REQ-017 The FSM SHALL have states EMPTY, FULL, and WAIT.
REQ-018 EMPTY + press SHALL capture, go to FULL, and set valid=1.
REQ-019 EMPTY + rd_req without press SHALL go to WAIT and set waiting=1.
REQ-020 EMPTY + press + rd_req in the same cycle SHALL let press win and go to FULL; the ack then follows from FULL.
REQ-021 FULL + rd_req without press SHALL assert rd_ack next cycle, go to EMPTY, and clear valid and overrun.
REQ-022 FULL + press without rd_req SHALL overwrite inpval, set overrun=1, and stay FULL.
REQ-023 FULL + press + rd_req in the same cycle SHALL overwrite inpval, set overrun, and defer the ack by one cycle, which then delivers the new value.
REQ-024 WAIT + press SHALL capture and assert rd_ack on the same edge, go to EMPTY, clear waiting, and leave valid=0.
REQ-025 WAIT with rd_req dropped and no press SHALL cancel the request, go to EMPTY, and clear waiting without an ack.
REQ-026 rd_req SHALL be ignored in any cycle where rd_ack=1; the processor drops rd_req the cycle after it sees rd_ack.
REQ-027 inpval SHALL change only on a capture and SHALL be stable while valid=1 and no press occurs.
REQ-028 rd_ack SHALL never be high for 2 consecutive cycles.

Reset
REQ-029 n_reset=0 at an edge SHALL set state=EMPTY, inpval=0, rd_ack=0, valid=0, overrun=0, waiting=0, clear the synchronizers and counter, and set btn_db=0.
REQ-030 Reset mid-operation (any state) SHALL take effect at that edge and abandon any pending request without an ack.
REQ-031 A button still held when reset is released SHALL produce exactly one press after DEB_CYCLES stable cycles.

Verification (DEB_CYCLES=4)
REQ-032 Capture and read: inp=16'h1234, btn high 12 cycles -> valid=1 within 8 cycles of btn rising, inpval=16'h1234; then rd_req -> exactly one rd_ack with 16'h1234, then valid=0.
REQ-033 Bounce rejection: btn toggling high 3 / low 1 repeatedly -> valid stays 0; then held high 6 cycles -> exactly one capture.
REQ-034 Stall: rd_req with state EMPTY -> waiting=1; press with inp=16'hBEEF -> rd_ack=1 with inpval=16'hBEEF, then waiting=0 and valid=0.
REQ-035 Overrun: press with 16'h0001, then press with 16'h0002, no read -> overrun=1, inpval=16'h0002; read -> rd_ack, then overrun=0.
REQ-036 Cancel and reset: rd_req drops in WAIT -> EMPTY, no ack; n_reset=0 in WAIT with rd_req high -> all outputs 0 next cycle, no ack.
REQ-037 Simultaneous events: press and rd_req in the same cycle in EMPTY and in FULL -> behaviour per REQ-020 and REQ-023, single rd_ack, correct value.

Source files
------------

// File: rtl/in_port.sv
// in_port: switch-bank input port with a debounced capture button and a
// request/acknowledge handshake toward the processor's IN instruction.
module in_port #(
    parameter logic [15:0] DEB_CYCLES = 16'd50000
) (
    input  logic        clock,
    input  logic        n_reset,
    input  logic [15:0] inp,
    input  logic        btn,
    input  logic        rd_req,
    output logic [15:0] inpval,
    output logic        rd_ack,
    output logic        valid,
    output logic        overrun,
    output logic        waiting
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        WAIT  = 2'd2
    } state_t;

    logic [15:0] inp_s1_q, inp_s2_q;
    logic        btn_s1_q, btn_s2_q;
    logic [15:0] cnt_q, cnt_d;
    logic        btn_db_q, btn_db_d;
    logic        press;

    state_t      state_q, state_d;
    logic [15:0] inpval_q, inpval_d;
    logic        rd_ack_q, rd_ack_d;
    logic        valid_q, valid_d;
    logic        overrun_q, overrun_d;
    logic        waiting_q, waiting_d;
    logic        req;

    // Two-flop synchronizers for the asynchronous switches and button.
    always_ff @(posedge clock) begin
        if (!n_reset) begin
            inp_s1_q <= '0;
            inp_s2_q <= '0;
            btn_s1_q <= 1'b0;
            btn_s2_q <= 1'b0;
        end else begin
            inp_s1_q <= inp;
            inp_s2_q <= inp_s1_q;
            btn_s1_q <= btn;
            btn_s2_q <= btn_s1_q;
        end
    end

    // Debounce: count consecutive disagreeing cycles, flip btn_db once the
    // count reaches DEB_CYCLES; only the rising flip is reported as a press.
    always_comb begin
        cnt_d    = cnt_q;
        btn_db_d = btn_db_q;
        press    = 1'b0;
        if (btn_s2_q == btn_db_q) begin
            cnt_d = '0;
        end else if (({1'b0, cnt_q} + 17'd1) >= {1'b0, DEB_CYCLES}) begin
            btn_db_d = ~btn_db_q;
            cnt_d    = '0;
            press    = ~btn_db_q;
        end else if (cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Debounce state registers.
    always_ff @(posedge clock) begin
        if (!n_reset) begin
            cnt_q    <= '0;
            btn_db_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            btn_db_q <= btn_db_d;
        end
    end

    // A request is not looked at during the cycle its acknowledge is shown,
    // because the processor only drops rd_req after seeing rd_ack.
    assign req = rd_req & ~rd_ack_q;

    // Port state machine: press always wins over a concurrent request, so a
    // simultaneous press+request in FULL delivers the new value one cycle later.
    always_comb begin
        state_d   = state_q;
        inpval_d  = inpval_q;
        rd_ack_d  = 1'b0;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        waiting_d = waiting_q;
        unique case (state_q)
            EMPTY: begin
                if (press) begin
                    inpval_d = inp_s2_q;
                    valid_d  = 1'b1;
                    state_d  = FULL;
                end else if (req) begin
                    waiting_d = 1'b1;
                    state_d   = WAIT;
                end
            end
            FULL: begin
                if (press) begin
                    inpval_d  = inp_s2_q;
                    overrun_d = 1'b1;
                end else if (req) begin
                    rd_ack_d  = 1'b1;
                    valid_d   = 1'b0;
                    overrun_d = 1'b0;
                    state_d   = EMPTY;
                end
            end
            WAIT: begin
                if (press) begin
                    inpval_d  = inp_s2_q;
                    rd_ack_d  = 1'b1;
                    waiting_d = 1'b0;
                    state_d   = EMPTY;
                end else if (!rd_req) begin
                    waiting_d = 1'b0;
                    state_d   = EMPTY;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    // State and registered outputs; reset abandons any pending request.
    always_ff @(posedge clock) begin
        if (!n_reset) begin
            state_q   <= EMPTY;
            inpval_q  <= '0;
            rd_ack_q  <= 1'b0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            waiting_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            inpval_q  <= inpval_d;
            rd_ack_q  <= rd_ack_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            waiting_q <= waiting_d;
        end
    end

    assign inpval  = inpval_q;
    assign rd_ack  = rd_ack_q;
    assign valid   = valid_q;
    assign overrun = overrun_q;
    assign waiting = waiting_q;

endmodule
